// File: rtl/eth_pkg.sv
// Ethernet receive helpers: GMII framing constants, the receive FSM state
// type and a byte-wide reflected CRC-32 step shared by the RX and TX FCS paths.
package eth_pkg;

    localparam logic [7:0]  PREAMBLE    = 8'h55;
    localparam logic [7:0]  SFD         = 8'hD5;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    // Register value left after running the CRC over data plus a correct FCS.
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_DROP
    } rxfcs_state_t;

    // One byte of reflected CRC-32, bits consumed LSB first, no final inversion.
    function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/gmii_rx_fcs_if.sv
// GMII receive pins on one side, stripped frame stream plus status and
// error counters on the other.
interface gmii_rx_fcs_if;

    logic [7:0]  rxd;
    logic        rx_dv;
    logic        rx_er;

    logic [7:0]  dout;
    logic        dout_valid;
    logic        sof;
    logic        eof;
    logic        frame_ok;
    logic [15:0] frame_len;

    logic [31:0] cnt_good;
    logic [31:0] cnt_crc;
    logic [31:0] cnt_runt;
    logic [31:0] cnt_giant;
    logic [31:0] cnt_rxer;

    // PHY / bench side: drives the GMII pins, observes the frame stream.
    modport master (
        output rxd, rx_dv, rx_er,
        input  dout, dout_valid, sof, eof, frame_ok, frame_len,
        input  cnt_good, cnt_crc, cnt_runt, cnt_giant, cnt_rxer
    );

    // Receiver side.
    modport slave (
        input  rxd, rx_dv, rx_er,
        output dout, dout_valid, sof, eof, frame_ok, frame_len,
        output cnt_good, cnt_crc, cnt_runt, cnt_giant, cnt_rxer
    );

endinterface

// File: rtl/crc32_d8_reg.sv
// Registered byte-wide CRC-32 engine: init loads the seed, en folds in one byte.
module crc32_d8_reg
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    // Seed takes precedence over an update in the same cycle.
    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC_INIT;
        end else if (en) begin
            crc_d = crc32_d8(crc_q, data);
        end
    end

    // CRC state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/gmii_rx_fcs.sv
// GMII receive front end: strips preamble/SFD, hides the FCS behind a 4-byte
// delay line, checks CRC and length, and reports a one-cycle status per frame.
module gmii_rx_fcs
    import eth_pkg::*;
#(
    parameter int MINLEN = 64,
    parameter int MAXLEN = 1518
) (
    input  logic         clk,
    input  logic         reset_n,
    gmii_rx_fcs_if.slave bus
);

    rxfcs_state_t    state_q, state_d;
    logic            armed_q;
    logic [15:0]     len_q, len_d;
    logic [3:0][7:0] dl_q, dl_d;
    logic            er_q, er_d;

    logic [7:0]      dout_q, dout_d;
    logic            dout_valid_q, dout_valid_d;
    logic            sof_q, sof_d;
    logic            eof_q, eof_d;
    logic            frame_ok_q, frame_ok_d;
    logic [15:0]     frame_len_q, frame_len_d;

    logic [31:0]     cnt_good_q, cnt_good_d;
    logic [31:0]     cnt_crc_q, cnt_crc_d;
    logic [31:0]     cnt_runt_q, cnt_runt_d;
    logic [31:0]     cnt_giant_q, cnt_giant_d;
    logic [31:0]     cnt_rxer_q, cnt_rxer_d;

    logic            crc_init;
    logic            crc_en;
    logic [31:0]     crc_val;
    logic            crc_bad;
    logic            len_runt;
    logic            len_giant;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Reported length excludes the FCS and never goes negative.
    function automatic logic [15:0] strip_fcs(input logic [15:0] v);
        return (v > 16'd4) ? v - 16'd4 : 16'd0;
    endfunction

    crc32_d8_reg u_crc (
        .clk     (clk),
        .reset_n (reset_n),
        .init    (crc_init),
        .en      (crc_en),
        .data    (bus.rxd),
        .crc     (crc_val)
    );

    assign crc_bad   = (crc_val != CRC_RESIDUE);
    assign len_runt  = ({16'd0, len_q} < 32'(MINLEN));
    assign len_giant = ({16'd0, len_q} > 32'(MAXLEN));

    // Next-state, datapath and status decode for the receive FSM.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        dl_d         = dl_q;
        er_d         = er_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        sof_d        = 1'b0;
        eof_d        = 1'b0;
        frame_ok_d   = frame_ok_q;
        frame_len_d  = frame_len_q;
        cnt_good_d   = cnt_good_q;
        cnt_crc_d    = cnt_crc_q;
        cnt_runt_d   = cnt_runt_q;
        cnt_giant_d  = cnt_giant_q;
        cnt_rxer_d   = cnt_rxer_q;
        crc_init     = 1'b0;
        crc_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                er_d = 1'b0;
                if (bus.rx_dv) begin
                    // A frame already in flight when reset lifted is skipped whole.
                    if (!armed_q) begin
                        state_d = ST_DROP;
                    end else if (bus.rxd == PREAMBLE) begin
                        state_d = ST_PRE;
                    end else if (bus.rxd == SFD) begin
                        state_d  = ST_DATA;
                        crc_init = 1'b1;
                        len_d    = 16'd0;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end

            ST_PRE: begin
                if (!bus.rx_dv) begin
                    state_d = ST_IDLE;
                end else if (bus.rx_er) begin
                    state_d = ST_DROP;
                end else if (bus.rxd == SFD) begin
                    state_d  = ST_DATA;
                    crc_init = 1'b1;
                    len_d    = 16'd0;
                end else if (bus.rxd != PREAMBLE) begin
                    state_d = ST_DROP;
                end
            end

            ST_DATA: begin
                if (!bus.rx_dv) begin
                    state_d     = ST_IDLE;
                    eof_d       = 1'b1;
                    frame_len_d = strip_fcs(len_q);
                    frame_ok_d  = !er_q && !crc_bad && !len_runt && !len_giant;
                    if (er_q) begin
                        cnt_rxer_d = cnt_rxer_q + 32'd1;
                    end else if (len_runt) begin
                        cnt_runt_d = cnt_runt_q + 32'd1;
                    end else if (len_giant) begin
                        cnt_giant_d = cnt_giant_q + 32'd1;
                    end else if (crc_bad) begin
                        cnt_crc_d = cnt_crc_q + 32'd1;
                    end else begin
                        cnt_good_d = cnt_good_q + 32'd1;
                    end
                end else if (bus.rx_er) begin
                    state_d = ST_DROP;
                    er_d    = 1'b1;
                end else begin
                    crc_en = 1'b1;
                    len_d  = sat_inc16(len_q);
                    dl_d   = {dl_q[2:0], bus.rxd};
                    // The oldest byte is released only once four newer ones
                    // exist, so the trailing FCS never reaches dout.
                    if (len_q >= 16'd4) begin
                        dout_d       = dl_q[3];
                        dout_valid_d = 1'b1;
                        sof_d        = (len_q == 16'd4);
                    end
                end
            end

            ST_DROP: begin
                if (!bus.rx_dv) begin
                    state_d = ST_IDLE;
                    er_d    = 1'b0;
                    // Only a frame aborted from DATA owes gmii2udp a status.
                    if (er_q) begin
                        eof_d       = 1'b1;
                        frame_ok_d  = 1'b0;
                        frame_len_d = strip_fcs(len_q);
                        cnt_rxer_d  = cnt_rxer_q + 32'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, status outputs and event counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed_q      <= 1'b0;
            len_q        <= 16'd0;
            dl_q         <= '0;
            er_q         <= 1'b0;
            dout_q       <= 8'd0;
            dout_valid_q <= 1'b0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_len_q  <= 16'd0;
            cnt_good_q   <= 32'd0;
            cnt_crc_q    <= 32'd0;
            cnt_runt_q   <= 32'd0;
            cnt_giant_q  <= 32'd0;
            cnt_rxer_q   <= 32'd0;
        end else begin
            armed_q      <= 1'b1;
            len_q        <= len_d;
            dl_q         <= dl_d;
            er_q         <= er_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sof_q        <= sof_d;
            eof_q        <= eof_d;
            frame_ok_q   <= frame_ok_d;
            frame_len_q  <= frame_len_d;
            cnt_good_q   <= cnt_good_d;
            cnt_crc_q    <= cnt_crc_d;
            cnt_runt_q   <= cnt_runt_d;
            cnt_giant_q  <= cnt_giant_d;
            cnt_rxer_q   <= cnt_rxer_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.sof        = sof_q;
    assign bus.eof        = eof_q;
    assign bus.frame_ok   = frame_ok_q;
    assign bus.frame_len  = frame_len_q;
    assign bus.cnt_good   = cnt_good_q;
    assign bus.cnt_crc    = cnt_crc_q;
    assign bus.cnt_runt   = cnt_runt_q;
    assign bus.cnt_giant  = cnt_giant_q;
    assign bus.cnt_rxer   = cnt_rxer_q;

endmodule

// File: tb/tb_gmii_rx_fcs.sv
// Directed bench for gmii_rx_fcs: frames are built here with their own FCS,
// and every output is compared against values derived from the stimulus.
module tb_gmii_rx_fcs;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    gmii_rx_fcs_if bus();

    gmii_rx_fcs #(
        .MINLEN (64),
        .MAXLEN (1518)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #4 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed stream, collected on the falling edge.
    logic [7:0]  got_q[$];
    logic        eok_q[$];
    logic [15:0] elen_q[$];
    int sof_n        = 0;
    int sof_cyc      = 0;
    int last_dv_cyc  = 0;
    int last_eof_cyc = 0;

    always @(negedge clk) begin
        if (bus.dout_valid === 1'b1) begin
            got_q.push_back(bus.dout);
            last_dv_cyc <= cyc;
        end
        if (bus.sof === 1'b1) begin
            sof_n   <= sof_n + 1;
            sof_cyc <= cyc;
        end
        if (bus.eof === 1'b1) begin
            eok_q.push_back(bus.frame_ok);
            elen_q.push_back(bus.frame_len);
            last_eof_cyc <= cyc;
        end
    end

    logic [7:0] tx_q[$];
    int b0_cyc  = 0;
    int dv0_cyc = 0;

    // Standard Ethernet FCS over tx_q[0..n-1], bit-serial, final inversion.
    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c;
        logic [7:0]  cur;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            cur = tx_q[i];
            for (int b = 0; b < 8; b++) begin
                c   = (c[0] ^ cur[0]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
                cur = cur >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic e);
        @(posedge clk);
        #1;
        bus.rx_dv = 1'b1;
        bus.rxd   = d;
        bus.rx_er = e;
    endtask

    task automatic drive_idle();
        @(posedge clk);
        #1;
        bus.rx_dv = 1'b0;
        bus.rxd   = 8'h00;
        bus.rx_er = 1'b0;
    endtask

    // Preamble, SFD, payload, FCS (optionally corrupted), then one idle byte.
    task automatic send_frame(input int npre, input int npay, input int seed,
                              input bit flip, input int er_at);
        logic [31:0] fcs;
        tx_q = {};
        for (int i = 0; i < npay; i++) tx_q.push_back(8'(i * 13 + seed));
        fcs = fcs_of(npay);
        if (flip) fcs[0] = ~fcs[0];
        for (int j = 0; j < 4; j++) tx_q.push_back(fcs[8*j +: 8]);
        for (int i = 0; i < npre; i++) drive(8'h55, 1'b0);
        drive(8'hD5, 1'b0);
        for (int i = 0; i < npay + 4; i++) begin
            drive(tx_q[i], i == er_at);
            if (i == 0) b0_cyc = cyc + 1;
        end
        drive_idle();
        dv0_cyc = cyc + 1;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    // Checks for the single frame just sent; flen < 0 skips the length check.
    task automatic check_frame(input string nm, input int bg, input int be, input int bs,
                               input int nout, input logic ok, input int flen);
        int nbad;
        nbad = 0;
        chk({nm, ".dout_count"}, got_q.size() - bg, nout);
        for (int i = 0; i < nout && bg + i < got_q.size(); i++)
            if (got_q[bg + i] !== tx_q[i]) nbad++;
        chk({nm, ".dout_data_errors"}, nbad, 0);
        chk({nm, ".sof_count"}, sof_n - bs, (nout > 0) ? 1 : 0);
        if (nout > 0) begin
            chk({nm, ".sof_latency"}, sof_cyc - b0_cyc, 4);
            chk({nm, ".dv_contiguous"}, last_dv_cyc - sof_cyc, nout - 1);
        end
        chk({nm, ".eof_count"}, eok_q.size() - be, 1);
        chk({nm, ".eof_time"}, last_eof_cyc, dv0_cyc);
        chk({nm, ".frame_ok"}, (eok_q.size() > be) ? eok_q[be] : 1'bx, ok);
        if (flen >= 0)
            chk({nm, ".frame_len"}, (elen_q.size() > be) ? elen_q[be] : 16'hxxxx, flen);
    endtask

    function automatic logic [31:0] cnt_total();
        return bus.cnt_good + bus.cnt_crc + bus.cnt_runt + bus.cnt_giant + bus.cnt_rxer;
    endfunction

    int bg, be, bs;

    initial begin
        bus.rx_dv = 1'b0;
        bus.rxd   = 8'h00;
        bus.rx_er = 1'b0;
        reset_n   = 1'b0;
        repeat (3) @(posedge clk);

        // Frame starts while reset is held; outputs must stay cleared.
        for (int i = 0; i < 5; i++) drive(8'h55, 1'b0);
        @(negedge clk);
        chk("rst.strobes", {bus.dout_valid, bus.sof, bus.eof, bus.frame_ok}, 0);
        chk("rst.dout", bus.dout, 0);
        chk("rst.frame_len", bus.frame_len, 0);
        chk("rst.counters", bus.cnt_good | bus.cnt_crc | bus.cnt_runt | bus.cnt_giant | bus.cnt_rxer, 0);

        // Release mid-frame: the rest, including a SFD, must be ignored.
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(8'h55, 1'b0);
        drive(8'h55, 1'b0);
        drive(8'hD5, 1'b0);
        for (int i = 0; i < 70; i++) drive(8'(i * 7 + 1), 1'b0);
        drive_idle();
        settle();
        chk("midrst.dout_count", got_q.size(), 0);
        chk("midrst.eof_count", eok_q.size(), 0);
        chk("midrst.counters", cnt_total(), 0);

        // Minimum-size good frame.
        bg = got_q.size(); be = eok_q.size(); bs = sof_n;
        send_frame(7, 60, 3, 1'b0, -1);
        settle();
        check_frame("min_good", bg, be, bs, 60, 1'b1, 60);
        chk("min_good.cnt_good", bus.cnt_good, 1);
        chk("min_good.cnt_total", cnt_total(), 1);

        // Same frame, FCS bit 0 flipped.
        bg = got_q.size(); be = eok_q.size(); bs = sof_n;
        send_frame(7, 60, 3, 1'b1, -1);
        settle();
        check_frame("crc_bad", bg, be, bs, 60, 1'b0, 60);
        chk("crc_bad.cnt_crc", bus.cnt_crc, 1);
        chk("crc_bad.cnt_total", cnt_total(), 2);

        // Runt: 40 payload + FCS = 44 bytes.
        bg = got_q.size(); be = eok_q.size(); bs = sof_n;
        send_frame(7, 40, 91, 1'b0, -1);
        settle();
        check_frame("runt", bg, be, bs, 40, 1'b0, 40);
        chk("runt.cnt_runt", bus.cnt_runt, 1);
        chk("runt.cnt_total", cnt_total(), 3);

        // Giant: 1515 payload + FCS = 1519 bytes.
        bg = got_q.size(); be = eok_q.size(); bs = sof_n;
        send_frame(7, 1515, 17, 1'b0, -1);
        settle();
        check_frame("giant", bg, be, bs, 1515, 1'b0, 1515);
        chk("giant.cnt_giant", bus.cnt_giant, 1);
        chk("giant.cnt_total", cnt_total(), 4);

        // Only the FCS after the SFD: no data, length floors to 0.
        bg = got_q.size(); be = eok_q.size(); bs = sof_n;
        send_frame(7, 0, 0, 1'b0, -1);
        settle();
        check_frame("empty", bg, be, bs, 0, 1'b0, 0);
        chk("empty.cnt_runt", bus.cnt_runt, 2);
        chk("empty.cnt_total", cnt_total(), 5);

        // rx_er on payload byte 20: bytes 0..15 are out by then, nothing after.
        bg = got_q.size(); be = eok_q.size(); bs = sof_n;
        send_frame(7, 100, 55, 1'b0, 20);
        settle();
        check_frame("rxer", bg, be, bs, 16, 1'b0, -1);
        chk("rxer.cnt_rxer", bus.cnt_rxer, 1);
        chk("rxer.cnt_crc_unchanged", bus.cnt_crc, 1);
        chk("rxer.cnt_total", cnt_total(), 6);

        // Two good frames, one idle cycle apart, second with a short preamble.
        bg = got_q.size(); be = eok_q.size(); bs = sof_n;
        send_frame(7, 64, 200, 1'b0, -1);
        send_frame(2, 70, 77, 1'b0, -1);
        settle();
        chk("b2b.eof_count", eok_q.size() - be, 2);
        chk("b2b.ok_first", (eok_q.size() > be) ? eok_q[be] : 1'bx, 1);
        chk("b2b.ok_second", (eok_q.size() > be + 1) ? eok_q[be + 1] : 1'bx, 1);
        chk("b2b.len_first", (elen_q.size() > be) ? elen_q[be] : 16'hxxxx, 64);
        chk("b2b.len_second", (elen_q.size() > be + 1) ? elen_q[be + 1] : 16'hxxxx, 70);
        chk("b2b.sof_count", sof_n - bs, 2);
        chk("b2b.dout_count", got_q.size() - bg, 134);
        chk("b2b.eof_time_second", last_eof_cyc, dv0_cyc);
        chk("b2b.cnt_good", bus.cnt_good, 3);
        chk("b2b.cnt_total", cnt_total(), 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/gmii_rx_fcs.md
# gmii_rx_fcs

Receive-side GMII front end that sits between the PHY/SGMII GMII receive pins and `gmii2udp`. It strips the preamble and SFD, checks length and the Ethernet FCS (CRC-32), and delivers the frame bytes without the FCS. At end of frame it reports a one-cycle status (good/bad, length), so `gmii2udp` can commit or discard the frame. It also keeps wrapping error counters for register readback.

## Interface
Parameters:
- `MINLEN`, 64: minimum legal frame length in bytes, including FCS.
- `MAXLEN`, 1518: maximum legal frame length in bytes, including FCS.

Ports:
- `clk`  in  1  GMII receive clock (`rx_clk`, 125 MHz).
- `reset_n`  in  1  asynchronous, active-low reset.
- `rxd`  in  8  GMII receive data.
- `rx_dv`  in  1  GMII data valid.
- `rx_er`  in  1  GMII receive error.
- `dout`  out  8  frame byte (destination MAC first, FCS excluded).
- `dout_valid`  out  1  `dout` is valid this cycle.
- `sof`  out  1  with the first `dout_valid` of a frame.
- `eof`  out  1  one-cycle end-of-frame status strobe.
- `frame_ok`  out  1  valid with `eof`: CRC good, length in range, no `rx_er`.
- `frame_len`  out  16  valid with `eof`: count of bytes after the SFD, minus 4 (floor 0).
- `cnt_good`, `cnt_crc`, `cnt_runt`, `cnt_giant`, `cnt_rxer`  out  32 each  wrapping event counters.

## Operation
- States: IDLE, PRE, DATA, DROP.
- IDLE:
  - `rx_dv`=1 with `rxd`=0x55 → PRE.
  - `rx_dv`=1 with `rxd`=0xD5 → DATA (preamble fully lost is tolerated).
  - `rx_dv`=1 with any other byte → DROP.
- PRE:
  - 0x55 stays in PRE.
  - 0xD5 → DATA.
  - Any other byte, `rx_er`, or `rx_dv`=0 → DROP, or IDLE if `rx_dv`=0.
  - No `eof` is issued for a frame that never reached DATA.
- DATA:
  - Every byte enters a 4-byte delay line and the CRC.
  - A byte leaves the delay line as `dout` once 4 newer bytes have been received, so the FCS is never output.
  - Length counter is 16 bits and saturates at 0xFFFF.
- DATA exit on `rx_dv`=0 → IDLE. `eof` is issued with status:
  - `frame_ok` = (CRC residue == 0xDEBB20E3) && MINLEN ≤ len ≤ MAXLEN && no `rx_er` seen.
  - Exactly one counter increments, in this priority: `cnt_rxer` (rx_er seen), `cnt_runt` (len < MINLEN), `cnt_giant` (len > MAXLEN), `cnt_crc` (residue mismatch), `cnt_good` (otherwise).
- DATA on `rx_er`=1 → DROP. The rx_er flag is latched and `dout` stops. On `rx_dv`=0, `eof` is issued with `frame_ok`=0 and `cnt_rxer` increments.
- DROP: wait for `rx_dv`=0, then → IDLE. `eof` is issued only if DROP was entered from DATA.
- CRC: reflected CRC-32, polynomial 0xEDB88320, register initialised to 0xFFFFFFFF at SFD, LSB-first per byte, run over all bytes after the SFD including the FCS.
- Reset (asynchronous assert, synchronous deassert usage):
  - All outputs and counters are 0; state is IDLE.
  - If `rx_dv`=1 at the first clock after reset release → DROP, so the block never syncs mid-frame.
- Reset asserted mid-frame: the frame is lost, with no `eof` and no counter change.

## Timing
- Data latency: byte k (k ≥ 0, the first after the SFD) sampled at cycle t appears on `dout` at t+5, provided byte k+4 exists. `dout_valid` is contiguous across the frame, with no gaps.
- `sof` coincides with the `dout_valid` of byte 0.
- `rx_dv` sampled low at cycle T → `eof`, `frame_ok` and `frame_len` are valid at T+1 for exactly one cycle. Counters update at T+1.
- The last `dout_valid` of a frame occurs at or before T.
- `dout`, `frame_len` and `frame_ok` hold their values when not strobed. Only the strobes (`dout_valid`, `sof`, `eof`) are defined.
- Back-to-back frames with a 1-cycle `rx_dv` gap: the next preamble byte may arrive at T+1 and is accepted, because the state is IDLE by then.
- A frame of ≤4 bytes after the SFD produces no `dout`, only `eof` with `frame_ok`=0 and `frame_len`=0.

## Structure
- Shared package `eth_pkg`:
  - constants: `PREAMBLE`=8'h55, `SFD`=8'hD5, `CRC_POLY`, `CRC_INIT`, `CRC_RESIDUE`;
  - the state enum `rxfcs_state_t`;
  - function `crc32_d8(crc, byte)`.
- Sub-module `crc32_d8_reg`: a registered CRC engine with `init` and `en` inputs, reused later by the TX FCS inserter.

## Test plan
- Min-size frame: 7×0x55, 0xD5, 60 payload bytes, correct FCS → 60 `dout` bytes matching the payload, `sof` on byte 0, `eof` with `frame_ok`=1 and `frame_len`=60; `cnt_good`=1.
- Same frame with FCS bit 0 flipped → identical `dout`; `eof` with `frame_ok`=0; `cnt_crc`=1.
- 40-byte payload with valid FCS → `frame_len`=40, `frame_ok`=0, `cnt_runt`=1. 1515-byte payload (1519 bytes with FCS) → `cnt_giant`=1.
- `rx_er` pulsed on payload byte 20 of a 100-byte frame → `dout` stops; one `eof` with `frame_ok`=0 after `rx_dv` falls; `cnt_rxer`=1.
- Two good frames separated by one idle cycle, the second with only 2×0x55 of preamble → two `eof` strobes, both `frame_ok`=1; `cnt_good`=2.
- `reset_n` released while `rx_dv`=1 mid-frame, followed by a good frame → first frame ignored (no `dout`, no `eof`); second frame accepted; `cnt_good`=1.
